// File: rtl/trg_tstamp_pkg.sv
// Shared constants for the trigger timestamp block: register addresses, CMD codes and
// the read word returned for unmapped addresses.
package trg_tstamp_pkg;

  localparam logic [7:0] ADDR_STATUS     = 8'h00;
  localparam logic [7:0] ADDR_CONFIG     = 8'h01;
  localparam logic [7:0] ADDR_CMD        = 8'h02;
  localparam logic [7:0] ADDR_HEAD0      = 8'h03;
  localparam logic [7:0] ADDR_HEAD1      = 8'h04;
  localparam logic [7:0] ADDR_HEAD2      = 8'h05;
  localparam logic [7:0] ADDR_HEAD3      = 8'h06;
  localparam logic [7:0] ADDR_TRGCNT_LO  = 8'h07;
  localparam logic [7:0] ADDR_TRGCNT_HI  = 8'h08;
  localparam logic [7:0] ADDR_LOSTCNT    = 8'h09;
  localparam logic [7:0] ADDR_DEADTIME   = 8'h0A;

  localparam logic [15:0] CMD_POP    = 16'h0001;
  localparam logic [15:0] CMD_CLR    = 16'h0002;
  localparam logic [15:0] RD_DEFAULT = 16'hF001;

  typedef struct packed {
    logic pol;
    logic en;
  } cfg_t;

endpackage

// File: rtl/trg_tstamp_fifo.sv
// Note: the FIFO sub-module itself lives in rtl/ts_fifo.sv; this file only holds a
// thin alias so the codebase slice keeps a single sub-module implementation.
module trg_tstamp_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_clr,
  input  logic [63:0]           i_data,
  output logic [63:0]           o_head,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_empty,
  output logic                  o_nempty,
  output logic                  o_full,
  output logic                  o_accept
);

  ts_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_push   (i_push),
    .i_pop    (i_pop),
    .i_clr    (i_clr),
    .i_data   (i_data),
    .o_head   (o_head),
    .o_level  (o_level),
    .o_empty  (o_empty),
    .o_nempty (o_nempty),
    .o_full   (o_full),
    .o_accept (o_accept)
  );

endmodule

// File: rtl/ts_fifo.sv
// 64-bit synchronous timestamp FIFO; a push into a full FIFO is accepted only when a
// pop retires the head in the same cycle. Clear flushes and wins over push/pop.
module ts_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_clr,
  input  logic [63:0]           i_data,
  output logic [63:0]           o_head,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_empty,
  output logic                  o_nempty,
  output logic                  o_full,
  output logic                  o_accept
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_MAX = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [63:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_nempty;
  logic                  w_rd, w_wr;
  logic [DEPTH_LOG2:0]   w_level_nxt;

  assign o_full   = (r_level == LVL_MAX);
  assign w_rd     = i_pop & r_nempty & ~i_clr;
  assign w_wr     = i_push & ~i_clr & (~o_full | w_rd);
  assign o_accept = w_wr;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_rd)      w_level_nxt = r_level + LVL_ONE;
    else if (!w_wr && w_rd) w_level_nxt = r_level - LVL_ONE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_nempty <= 1'b0;
    end else if (i_clr) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_nempty <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd) r_rptr <= r_rptr + PTR_ONE;
      r_level  <= w_level_nxt;
      r_nempty <= (w_level_nxt != '0);
    end
  end

  // Storage needs no reset: the pointers and level alone decide what is visible.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  assign o_head   = r_mem[r_rptr];
  assign o_level  = r_level;
  assign o_empty  = ~r_nempty;
  assign o_nempty = r_nempty;

endmodule

// File: rtl/trg_tstamp.sv
// Trigger edge timestamper: captures tsys_i into a FIFO on each enabled trigger edge,
// with accepted/lost counters on a 16-bit register bus. TRG_TSTAMP_DEADTIME_EN adds dead time.
module trg_tstamp
  import trg_tstamp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trg_i,
  input  logic [63:0] tsys_i,
  input  logic        reg_we_i,
  input  logic [7:0]  reg_addr_i,
  input  logic [15:0] reg_data_i,
  output logic [15:0] reg_data_o,
  output logic        nempty_o
);

  cfg_t                r_cfg;
  logic                r_trg_q;
  logic                r_ovf;
  logic [31:0]         r_trgcnt;
  logic [15:0]         r_lostcnt;

  logic                w_cmd, w_pop, w_clr, w_edge, w_cand, w_push, w_lost;
  logic                w_accept, w_empty, w_full;
  logic [63:0]         w_head;
  logic [DEPTH_LOG2:0] w_level;
  logic [15:0]         w_status;

  assign w_cmd  = reg_we_i && (reg_addr_i == ADDR_CMD);
  assign w_pop  = w_cmd && (reg_data_i == CMD_POP);
  assign w_clr  = w_cmd && (reg_data_i == CMD_CLR);
  assign w_edge = r_cfg.en & (r_cfg.pol ? (r_trg_q & ~trg_i) : (trg_i & ~r_trg_q));

`ifdef TRG_TSTAMP_DEADTIME_EN
  logic [15:0] r_deadtime;
  logic [15:0] r_dead_cnt;

  assign w_cand = w_edge & (r_dead_cnt == 16'd0);

  // A lost (full) trigger does not restart the dead time; only accepted ones do.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_deadtime <= 16'd0;
      r_dead_cnt <= 16'd0;
    end else begin
      if (reg_we_i && reg_addr_i == ADDR_DEADTIME) r_deadtime <= reg_data_i;
      if (w_clr)                   r_dead_cnt <= 16'd0;
      else if (w_accept)           r_dead_cnt <= r_deadtime;
      else if (r_dead_cnt != 16'd0) r_dead_cnt <= r_dead_cnt - 16'd1;
    end
  end
`else
  assign w_cand = w_edge;
`endif

  assign w_push = w_cand & ~w_clr;
  assign w_lost = w_push & ~w_accept;

  ts_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_clr    (w_clr),
    .i_data   (tsys_i),
    .o_head   (w_head),
    .o_level  (w_level),
    .o_empty  (w_empty),
    .o_nempty (nempty_o),
    .o_full   (w_full),
    .o_accept (w_accept)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cfg     <= '0;
      r_trg_q   <= 1'b0;
      r_ovf     <= 1'b0;
      r_trgcnt  <= '0;
      r_lostcnt <= '0;
    end else begin
      r_trg_q <= trg_i;
      if (reg_we_i && reg_addr_i == ADDR_CONFIG) r_cfg <= cfg_t'(reg_data_i[1:0]);
      if (w_clr) begin
        r_ovf     <= 1'b0;
        r_trgcnt  <= '0;
        r_lostcnt <= '0;
      end else begin
        if (w_accept) r_trgcnt <= r_trgcnt + 32'd1;
        if (w_lost) begin
          r_ovf <= 1'b1;
          if (r_lostcnt != 16'hFFFF) r_lostcnt <= r_lostcnt + 16'd1;
        end
      end
    end
  end

  assign w_status = {8'(w_level), 5'b0, r_ovf, w_full, w_empty};

  always_comb begin
    reg_data_o = RD_DEFAULT;
    case (reg_addr_i)
      ADDR_STATUS:    reg_data_o = w_status;
      ADDR_CONFIG:    reg_data_o = {14'b0, r_cfg};
      ADDR_CMD:       reg_data_o = 16'h0000;
      ADDR_HEAD0:     reg_data_o = w_empty ? 16'h0000 : w_head[15:0];
      ADDR_HEAD1:     reg_data_o = w_empty ? 16'h0000 : w_head[31:16];
      ADDR_HEAD2:     reg_data_o = w_empty ? 16'h0000 : w_head[47:32];
      ADDR_HEAD3:     reg_data_o = w_empty ? 16'h0000 : w_head[63:48];
      ADDR_TRGCNT_LO: reg_data_o = r_trgcnt[15:0];
      ADDR_TRGCNT_HI: reg_data_o = r_trgcnt[31:16];
      ADDR_LOSTCNT:   reg_data_o = r_lostcnt;
`ifdef TRG_TSTAMP_DEADTIME_EN
      ADDR_DEADTIME:  reg_data_o = r_deadtime;
`endif
      default:        reg_data_o = RD_DEFAULT;
    endcase
  end

endmodule

// File: doc/trg_tstamp.md
Name: trg_tstamp

Overview:
- Downstream consumer of the 64-bit system timestamp counter's output.
- Detects trigger edges on trg_i and captures the current tsys_i value into a timestamp FIFO.
- Keeps accepted and lost trigger counters.
- Exposes everything on the same 16-bit register bus (8-bit address, combinational read data) used by the other DAQ control blocks.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; legal range 1..7, so the depth is 2..128 entries.

Ports:
- clk_i  in  1  system clock; every input is synchronous to it.
- rst_i  in  1  reset, asynchronous and active-high.
- trg_i  in  1  trigger level input, already synchronised to clk_i.
- tsys_i  in  64  free-running system timestamp.
- reg_we_i  in  1  register write strobe.
- reg_addr_i  in  8  register address.
- reg_data_i  in  16  register write data.
- reg_data_o  out  16  register read data; combinational from reg_addr_i.
- nempty_o  out  1  high while the FIFO holds at least one entry; registered.

Behaviour:
- Register map:
  - 0x00 STATUS, read-only: bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] fill level.
  - 0x01 CONFIG, read/write: bit0 enable, bit1 polarity (0 = rising edge, 1 = falling edge); other bits read 0.
  - 0x02 CMD, write-only, reads 0: 0x0001 POP, 0x0002 CLR; any other value is ignored.
  - 0x03..0x06 HEAD0..HEAD3: head-entry timestamp bits [15:0], [31:16], [47:32], [63:48]. They read 0 when the FIFO is empty.
  - 0x07/0x08 TRGCNT low/high: 32-bit count of accepted triggers; wraps.
  - 0x09 LOSTCNT: 16-bit count of dropped triggers; saturates at 0xFFFF.
  - Any other address reads 0xF001.
- Reset values:
  - CONFIG = 0, so the block is disabled and polarity is rising.
  - FIFO empty, overflow = 0, TRGCNT = 0, LOSTCNT = 0, nempty_o = 0.
  - Edge-detect register trg_q = 0.
- Edge detection:
  - trg_q <= trg_i on every cycle, regardless of enable. This prevents a false edge when enable is set while trg_i is already high.
  - edge = enable & (pol ? (trg_q & ~trg_i) : (trg_i & ~trg_q)).
- Capture: on an edge cycle, the tsys_i value of that same cycle is the value pushed.
- Latency: the entry becomes visible (empty=0, nempty_o=1, HEAD valid) on the cycle after the edge.
- Push with FIFO not full: entry written, TRGCNT incremented.
- Push with FIFO full:
  - No pop in the same cycle: entry dropped, overflow set to 1, LOSTCNT incremented (saturating), TRGCNT unchanged.
  - POP in the same cycle: both take effect; level is unchanged, the entry is accepted and TRGCNT is incremented.
- POP on an empty FIFO has no effect.
- POP on a non-empty FIFO advances the head on the next cycle. A simultaneous push into an empty FIFO is still accepted.
- CLR effects:
  - Flushes the FIFO and clears overflow, TRGCNT and LOSTCNT on the next edge of clk_i.
  - A trigger edge in the same cycle as CLR is discarded and not counted.
  - CONFIG is unchanged.
- A CONFIG write takes effect from the next cycle. An edge in the write cycle is evaluated with the old CONFIG.
- Level arithmetic: DEPTH_LOG2+1 bits, zero-extended into STATUS[15:8]. full means level == 2^DEPTH_LOG2.
- Asynchronous reset mid-operation returns every register to its reset value immediately. No partial entry survives.

Optional Feature:
- Macro: TRG_TSTAMP_DEADTIME_EN.
- When defined:
  - Adds register 0x0A DEADTIME (16-bit, read/write, reset 0).
  - After each accepted trigger, a down-counter is loaded with DEADTIME. Edges seen while the counter is non-zero are ignored: not pushed, not counted in TRGCNT or LOSTCNT.
  - DEADTIME = 0 means no dead time.
  - A dropped-on-full trigger does not start the dead time.
  - CLR zeroes the counter.
- When undefined:
  - Address 0x0A reads 0xF001.
  - Every edge is a push candidate.

Decomposition:
- Shared package trg_tstamp_pkg holds:
  - Register address constants 0x00..0x0A.
  - CMD_POP = 16'h0001, CMD_CLR = 16'h0002.
  - Default read word 16'hF001.
- One sub-module, ts_fifo: synchronous FIFO, 64 bits wide, with parameter DEPTH_LOG2.
  - Inputs: push, pop, clr. Outputs: head data, level, empty, full.
  - Implements the full push+pop rule.
  - Its reset is asynchronous and active-high, shared with the top level.

Test Plan:
- Reset, then CONFIG=1, rising edge on trg_i at tsys_i=0x0000_0001_2345_6789 -> next cycle: nempty_o=1, HEAD0..3 = 6789/2345/0001/0000, TRGCNT=1.
- CONFIG=3 (falling), pulse trg_i high then low -> exactly one entry, captured at the cycle trg_i falls. With trg_i high when enable is set -> no entry.
- DEPTH_LOG2=2: five edges, no pops -> STATUS = 0x0406 (level 4, full, overflow), LOSTCNT=1, TRGCNT=4. Four POPs -> entries read in order, empty=1, HEAD reads 0.
- Full FIFO, edge in the same cycle as a POP write -> level stays 4, overflow stays 0, TRGCNT increments.
- CLR write in the same cycle as an edge -> FIFO empty, TRGCNT=0, LOSTCNT=0, overflow=0, CONFIG retained.
- TRG_TSTAMP_DEADTIME_EN defined, DEADTIME=10: edges at cycles 0, 5 and 11 -> entries at 0 and 11 only, TRGCNT=2, LOSTCNT=0.
